// File: rtl/calc2_mp_engine.sv
// calc2_mp_engine: NUM_PORTS requesters share one add/sub unit and one shift
// unit through independent round-robin arbiters. Each port runs a small
// IDLE -> OP2 -> WAIT FSM and returns a registered one-cycle response.
// External buses use ascending [0:W-1] ranges; bit W-1 is the LSB.
module calc2_mp_engine #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [0:NUM_PORTS*4-1]        req_cmd_in,
  input  logic [0:NUM_PORTS*DATA_W-1]   req_data_in,
  output logic [0:NUM_PORTS*2-1]        out_resp,
  output logic [0:NUM_PORTS*DATA_W-1]   out_data,
  output logic [0:NUM_PORTS-1]          port_busy
);

  localparam int SHW = $clog2(DATA_W);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_OVF  = 2'd2;
  localparam logic [1:0] RESP_INV  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Command classification helpers
  function automatic logic is_addsub(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

  // Round-robin search starting at ptr; returns {found, index}
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic [PW:0] pick;
    int k;
    pick = {(PW+1){1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = (int'(ptr) + i) % NUM_PORTS;
      if (!pick[PW] && req[k]) pick = {1'b1, PW'(k)};
      else                     pick = pick;
    end
    return pick;
  endfunction

  // Pointer moves to the port after the winner, wrapping at NUM_PORTS
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    if (idx == PW'(NUM_PORTS - 1)) return {PW{1'b0}};
    else                           return idx + PW'(1);
  endfunction

  state_t              state_r  [NUM_PORTS];
  state_t              state_s  [NUM_PORTS];
  logic [3:0]          cmd_r    [NUM_PORTS];
  logic [DATA_W-1:0]   op1_r    [NUM_PORTS];
  logic [DATA_W-1:0]   op2_r    [NUM_PORTS];
  logic [1:0]          resp_r   [NUM_PORTS];
  logic [DATA_W-1:0]   data_r   [NUM_PORTS];
  logic [NUM_PORTS-1:0] busy_r;
  logic [3:0]          cmd_in_s  [NUM_PORTS];
  logic [DATA_W-1:0]   data_in_s [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_as_s, req_sh_s, gnt_as_s, gnt_sh_s, done_s;
  logic [PW-1:0]        as_ptr_r, sh_ptr_r, as_idx_s, sh_idx_s;
  logic [PW:0]          as_pick_s, sh_pick_s;
  logic                 as_any_s, sh_any_s;

  logic [DATA_W-1:0]    as_a_s, as_b_s, as_data_s, sh_data_s;
  logic [DATA_W:0]      as_sum_s;
  logic [1:0]           as_resp_s;
  logic [SHW-1:0]       sh_amt_s;

  // Unpack input buses and pack registered outputs per port
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port_io
    assign cmd_in_s[gp]                      = req_cmd_in[gp*4 +: 4];
    assign data_in_s[gp]                     = req_data_in[gp*DATA_W +: DATA_W];
    assign out_resp[gp*2 +: 2]               = resp_r[gp];
    assign out_data[gp*DATA_W +: DATA_W]     = data_r[gp];
    assign port_busy[gp]                     = busy_r[gp];
  end

  // Each port in WAIT requests the unit that matches its latched command
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_as_s[p] = (state_r[p] == ST_WAIT) && is_addsub(cmd_r[p]);
      req_sh_s[p] = (state_r[p] == ST_WAIT) && is_shift(cmd_r[p]);
    end
  end

  assign as_pick_s = rr_pick(req_as_s, as_ptr_r);
  assign sh_pick_s = rr_pick(req_sh_s, sh_ptr_r);
  assign as_any_s  = as_pick_s[PW];
  assign as_idx_s  = as_pick_s[PW-1:0];
  assign sh_any_s  = sh_pick_s[PW];
  assign sh_idx_s  = sh_pick_s[PW-1:0];

  // Decode grants and completion (granted, or invalid command finishing)
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_as_s[p] = as_any_s && (as_idx_s == PW'(p));
      gnt_sh_s[p] = sh_any_s && (sh_idx_s == PW'(p));
      done_s[p]   = (state_r[p] == ST_WAIT) &&
                    (gnt_as_s[p] || gnt_sh_s[p] ||
                     !(is_addsub(cmd_r[p]) || is_shift(cmd_r[p])));
    end
  end

  // Shared add/sub unit operating on the granted port's operands
  always_comb begin
    as_a_s    = op1_r[as_idx_s];
    as_b_s    = op2_r[as_idx_s];
    as_sum_s  = {1'b0, as_a_s} + {1'b0, as_b_s};
    as_resp_s = RESP_NONE;
    as_data_s = {DATA_W{1'b0}};
    case (cmd_r[as_idx_s])
      CMD_ADD: begin
        if (as_sum_s[DATA_W]) begin
          as_resp_s = RESP_OVF;
        end else begin
          as_resp_s = RESP_OK;
          as_data_s = as_sum_s[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (as_b_s > as_a_s) begin
          as_resp_s = RESP_OVF;
        end else begin
          as_resp_s = RESP_OK;
          as_data_s = as_a_s - as_b_s;
        end
      end
      default: begin
        as_resp_s = RESP_NONE;
        as_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Shared shift unit; amount is the low SHW bits of op2, zero fill
  always_comb begin
    sh_amt_s  = op2_r[sh_idx_s][SHW-1:0];
    sh_data_s = {DATA_W{1'b0}};
    case (cmd_r[sh_idx_s])
      CMD_SHL: sh_data_s = op1_r[sh_idx_s] << sh_amt_s;
      CMD_SHR: sh_data_s = op1_r[sh_idx_s] >> sh_amt_s;
      default: sh_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Per-port next-state logic
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_s[p] = state_r[p];
      case (state_r[p])
        ST_IDLE: begin
          if (cmd_in_s[p] != CMD_NOP) state_s[p] = ST_OP2;
          else                        state_s[p] = ST_IDLE;
        end
        ST_OP2:  state_s[p] = ST_WAIT;
        ST_WAIT: begin
          if (done_s[p]) state_s[p] = ST_IDLE;
          else           state_s[p] = ST_WAIT;
        end
        default: state_s[p] = ST_IDLE;
      endcase
    end
  end

  // Per-port state register
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state_r[p] <= ST_IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) state_r[p] <= state_s[p];
    end
  end

  // Round-robin pointers advance past each unit's winner
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      as_ptr_r <= {PW{1'b0}};
      sh_ptr_r <= {PW{1'b0}};
    end else begin
      if (as_any_s) as_ptr_r <= rr_next(as_idx_s);
      if (sh_any_s) sh_ptr_r <= rr_next(sh_idx_s);
    end
  end

  // Operand capture, busy flag and one-cycle response registers
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      busy_r <= {NUM_PORTS{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
        cmd_r[p]  <= CMD_NOP;
        op1_r[p]  <= {DATA_W{1'b0}};
        op2_r[p]  <= {DATA_W{1'b0}};
        resp_r[p] <= RESP_NONE;
        data_r[p] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_r[p] <= RESP_NONE;
        data_r[p] <= {DATA_W{1'b0}};
        case (state_r[p])
          ST_IDLE: begin
            if (cmd_in_s[p] != CMD_NOP) begin
              cmd_r[p]  <= cmd_in_s[p];
              op1_r[p]  <= data_in_s[p];
              busy_r[p] <= 1'b1;
            end
          end
          ST_OP2: op2_r[p] <= data_in_s[p];
          ST_WAIT: begin
            if (gnt_as_s[p]) begin
              resp_r[p] <= as_resp_s;
              data_r[p] <= as_data_s;
              busy_r[p] <= 1'b0;
            end else if (gnt_sh_s[p]) begin
              resp_r[p] <= RESP_OK;
              data_r[p] <= sh_data_s;
              busy_r[p] <= 1'b0;
            end else if (done_s[p]) begin
              resp_r[p] <= RESP_INV;
              busy_r[p] <= 1'b0;
            end
          end
          default: busy_r[p] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc2_mp_engine.sv
// Directed testbench for calc2_mp_engine: a 4-port/32-bit instance for the
// main scenarios and a 2-port/16-bit instance for the shift sweep.
module tb_calc2_mp_engine;

  logic        clk;
  logic        rst;
  logic [0:15]  cmd_a;
  logic [0:127] data_a;
  logic [0:7]   resp_a;
  logic [0:127] dout_a;
  logic [0:3]   busy_a;
  logic [0:7]   cmd_b;
  logic [0:31]  data_b;
  logic [0:3]   resp_b;
  logic [0:31]  dout_b;
  logic [0:1]   busy_b;

  int n_chk = 0;
  int n_err = 0;

  calc2_mp_engine #(.NUM_PORTS(4), .DATA_W(32)) dut_a (
    .c_clk(clk), .reset(rst), .req_cmd_in(cmd_a), .req_data_in(data_a),
    .out_resp(resp_a), .out_data(dout_a), .port_busy(busy_a));

  calc2_mp_engine #(.NUM_PORTS(2), .DATA_W(16)) dut_b (
    .c_clk(clk), .reset(rst), .req_cmd_in(cmd_b), .req_data_in(data_b),
    .out_resp(resp_b), .out_data(dout_b), .port_busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int p, input logic [3:0] c, input logic [31:0] d);
    cmd_a[p*4 +: 4]   = c;
    data_a[p*32 +: 32] = d;
  endtask

  task automatic set_b(input int p, input logic [3:0] c, input logic [15:0] d);
    cmd_b[p*4 +: 4]    = c;
    data_b[p*16 +: 16] = d;
  endtask

  // Single uncontended transaction on the 4-port instance
  task automatic run_a(input string tag, input int p, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed);
    int lat;
    set_a(p, c, a);
    tick();
    check_val({tag, "_busy1"}, 64'(busy_a[p]), 64'd1);
    set_a(p, 4'd0, b);
    tick();
    check_val({tag, "_busy2"}, 64'(busy_a[p]), 64'd1);
    lat = 2;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (resp_a[p*2 +: 2] != 2'd0) break;
    end
    set_a(p, 4'd0, 32'd0);
    check_val({tag, "_resp"}, 64'(resp_a[p*2 +: 2]), 64'(er));
    check_val({tag, "_data"}, 64'(dout_a[p*32 +: 32]), 64'(ed));
    check_val({tag, "_lat"}, 64'(lat), 64'd3);
    check_val({tag, "_busy0"}, 64'(busy_a[p]), 64'd0);
    tick();
    check_val({tag, "_pulse"}, 64'(resp_a), 64'd0);
  endtask

  // Single transaction on the 2-port/16-bit instance
  task automatic run_b(input string tag, input int p, input logic [3:0] c,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] er, input logic [15:0] ed);
    set_b(p, c, a);
    tick();
    set_b(p, 4'd0, b);
    tick();
    tick();
    set_b(p, 4'd0, 16'd0);
    check_val({tag, "_resp"}, 64'(resp_b[p*2 +: 2]), 64'(er));
    check_val({tag, "_data"}, 64'(dout_b[p*16 +: 16]), 64'(ed));
    tick();
  endtask

  logic [0:7] exp_vec;

  initial begin
    rst    = 1'b1;
    cmd_a  = '0;
    data_a = '0;
    cmd_b  = '0;
    data_b = '0;
    tick();
    tick();
    check_val("rst_resp", 64'(resp_a), 64'd0);
    check_val("rst_data", 64'(dout_a[0:63]), 64'd0);
    check_val("rst_busy", 64'(busy_a), 64'd0);
    rst = 1'b0;
    tick();

    // Basic add, other ports silent
    set_a(0, 4'd1, 32'h0000_0001);
    tick();
    check_val("t1_busy", 64'(busy_a), 64'h8);
    set_a(0, 4'd0, 32'h01FF_FFFF);
    tick();
    check_val("t1_early", 64'(resp_a), 64'd0);
    tick();
    check_val("t1_resp_all", 64'(resp_a), 64'h40);
    check_val("t1_data", 64'(dout_a[0:31]), 64'h0200_0000);
    check_val("t1_other_data", 64'(dout_a[32:127]), 64'd0);
    tick();
    check_val("t1_after", 64'(resp_a), 64'd0);

    // Arithmetic corners
    run_a("add_ovf", 0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
    run_a("sub_unf", 1, 4'd2, 32'h1, 32'hF, 2'd2, 32'h0);
    run_a("sub_ok",  2, 4'd2, 32'hF, 32'h1, 2'd1, 32'hE);
    run_a("sub_eq",  3, 4'd2, 32'h5, 32'h5, 2'd1, 32'h0);
    run_a("shl",     1, 4'd5, 32'h3, 32'h4, 2'd1, 32'h30);
    run_a("shr_amt", 0, 4'd6, 32'h8000_0000, 32'h3F, 2'd1, 32'h1);

    // Invalid commands
    run_a("inv3",  1, 4'd3,  32'h1234, 32'h1, 2'd3, 32'h0);
    run_a("inv4",  1, 4'd4,  32'h1234, 32'h1, 2'd3, 32'h0);
    run_a("inv15", 1, 4'd15, 32'h1234, 32'h1, 2'd3, 32'h0);

    // Commands while busy are ignored
    set_a(3, 4'd1, 32'h5);
    tick();
    set_a(3, 4'd2, 32'h7);
    tick();
    tick();
    set_a(3, 4'd0, 32'h0);
    check_val("hold_resp", 64'(resp_a[6:7]), 64'd1);
    check_val("hold_data", 64'(dout_a[96:127]), 64'hC);
    tick();
    check_val("hold_none1", 64'(resp_a), 64'd0);
    tick();
    check_val("hold_none2", 64'(resp_a), 64'd0);
    check_val("hold_busy", 64'(busy_a), 64'd0);

    // New command accepted in the response cycle
    set_a(0, 4'd1, 32'h7);
    tick();
    set_a(0, 4'd0, 32'h8);
    tick();
    tick();
    set_a(0, 4'd2, 32'h20);
    check_val("b2b_resp1", 64'(resp_a[0:1]), 64'd1);
    check_val("b2b_data1", 64'(dout_a[0:31]), 64'hF);
    tick();
    check_val("b2b_busy", 64'(busy_a[0]), 64'd1);
    set_a(0, 4'd0, 32'h8);
    tick();
    tick();
    set_a(0, 4'd0, 32'h0);
    check_val("b2b_resp2", 64'(resp_a[0:1]), 64'd1);
    check_val("b2b_data2", 64'(dout_a[0:31]), 64'h18);
    tick();

    // Burst 1: all four ports add together (pointer currently 1 after b2b)
    // Reset the pointer first so the burst order starts at port 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) set_a(p, 4'd1, 32'h10 + 32'(p));
    tick();
    for (int p = 0; p < 4; p++) set_a(p, 4'd0, 32'h100);
    tick();
    for (int p = 0; p < 4; p++) set_a(p, 4'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_vec = '0;
      exp_vec[k*2 +: 2] = 2'd1;
      check_val("burst1_resp", 64'(resp_a), 64'(exp_vec));
      check_val("burst1_data", 64'(dout_a[k*32 +: 32]), 64'h110 + 64'(k));
      if (k == 0) check_val("burst1_busy", 64'(busy_a), 64'h7);
    end
    tick();
    check_val("burst1_end", 64'(resp_a), 64'd0);
    check_val("burst1_idle", 64'(busy_a), 64'd0);

    // Burst 2: adds on 0,1,3 restart at port 0; shl on port 2 uncontended
    set_a(0, 4'd1, 32'h20);
    set_a(1, 4'd1, 32'h21);
    set_a(2, 4'd5, 32'h3);
    set_a(3, 4'd1, 32'h23);
    tick();
    set_a(0, 4'd0, 32'h200);
    set_a(1, 4'd0, 32'h200);
    set_a(2, 4'd0, 32'h4);
    set_a(3, 4'd0, 32'h200);
    tick();
    for (int p = 0; p < 4; p++) set_a(p, 4'd0, 32'h0);
    tick();
    check_val("burst2_c0", 64'(resp_a), 64'h44);
    check_val("burst2_d0", 64'(dout_a[0:31]), 64'h220);
    check_val("burst2_d2", 64'(dout_a[64:95]), 64'h30);
    tick();
    check_val("burst2_c1", 64'(resp_a), 64'h10);
    check_val("burst2_d1", 64'(dout_a[32:63]), 64'h221);
    tick();
    check_val("burst2_c2", 64'(resp_a), 64'h01);
    check_val("burst2_d3", 64'(dout_a[96:127]), 64'h223);
    tick();

    // Reset while three ports wait for the adder
    for (int p = 0; p < 3; p++) set_a(p, 4'd1, 32'h1);
    tick();
    for (int p = 0; p < 3; p++) set_a(p, 4'd0, 32'h2);
    tick();
    for (int p = 0; p < 3; p++) set_a(p, 4'd0, 32'h0);
    check_val("rst5_busy_pre", 64'(busy_a), 64'hE);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst5_resp", 64'(resp_a), 64'd0);
    check_val("rst5_busy", 64'(busy_a), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("rst5_quiet", 64'({resp_a, busy_a}), 64'd0);
    end
    run_a("post_rst", 2, 4'd1, 32'h40, 32'h2, 2'd1, 32'h42);

    // Narrow instance: shift sweep and amount wrap
    for (int n = 0; n < 16; n++) begin
      logic [15:0] one;
      one = 16'h0001;
      run_b("b_shl", 0, 4'd5, 16'h0001, 16'(n), 2'd1, one << n);
    end
    run_b("b_shr16", 0, 4'd6, 16'h8000, 16'd16, 2'd1, 16'h8000);
    run_b("b_shr15", 1, 4'd6, 16'h8000, 16'd15, 2'd1, 16'h0001);
    run_b("b_addovf", 1, 4'd1, 16'hFFFF, 16'h0001, 2'd2, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
